// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access unit: size codes, FSM states and
// small size helpers used by both the control path and the byte-lane datapath.
package mem_access_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_INV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } mem_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Address low bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    align_mask = 2'b00;
      SZ_H:    align_mask = 2'b01;
      default: align_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side request/response port of the MEM-stage access unit.
// Handshake: a request transfers on the rising edge where req_valid && req_ready;
// resp_valid is a single-cycle pulse carrying resp_rdata/resp_err and needs no ready.
interface mem_access_if;
  import mem_access_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/byte_lane_unit.sv
// Combinational big-endian lane logic: extracts and extends load data from a
// memory word, and merges right-aligned store data into the addressed lane.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Byte 0 lives in the most significant lane.
  always_comb begin
    lane_b = word[7:0];
    case (offset)
      2'd0:    lane_b = word[31:24];
      2'd1:    lane_b = word[23:16];
      2'd2:    lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    lane_h = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_data = word;
    case (size)
      SZ_B:    load_data = {{24{is_signed & lane_b[7]}}, lane_b};
      SZ_H:    load_data = {{16{is_signed & lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged_word = store_data;
    case (size)
      SZ_B: begin
        merged_word = word;
        case (offset)
          2'd0:    merged_word[31:24] = store_data[7:0];
          2'd1:    merged_word[23:16] = store_data[7:0];
          2'd2:    merged_word[15:8]  = store_data[7:0];
          default: merged_word[7:0]   = store_data[7:0];
        endcase
      end
      SZ_H: begin
        merged_word = offset[1] ? {word[31:16], store_data[15:0]}
                                : {store_data[15:0], word[15:0]};
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-write, big-endian data memory; sub-word stores
// are read-modify-write. Optional macro ALIGN_CHECK_EN rejects misaligned accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_access_if.slave req_if,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output mem_state_e  state_dbg
);

  mem_state_e  state, next_state;

  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic [1:0]  mask;
  logic [31:0] eff_addr;
  logic [32:0] end_addr;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept = req_if.req_valid && (state == IDLE);

  // Request decode: effective address, range and error classification.
  always_comb begin
    mask = align_mask(req_if.req_size);
`ifdef ALIGN_CHECK_EN
    eff_addr = req_if.req_addr;
`else
    eff_addr = {req_if.req_addr[31:2], req_if.req_addr[1:0] & ~mask};
`endif
    end_addr     = {1'b0, eff_addr} + 33'(size_bytes(req_if.req_size));
    out_of_range = end_addr > 33'(MEM_BYTES);
    req_err      = (req_if.req_size == SZ_INV) || out_of_range;
`ifdef ALIGN_CHECK_EN
    if ((req_if.req_addr[1:0] & mask) != 2'b00) req_err = 1'b1;
`endif
  end

  byte_lane_unit u_lanes (
    .word        (read_data),
    .offset      (offset_q),
    .size        (size_q),
    .is_signed   (signed_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                    next_state = DONE;
          else if (!req_if.req_write)     next_state = RD;
          else if (req_if.req_size == SZ_W) next_state = WR;
          else                            next_state = RMW_RD;
        end
      end
      RD:      next_state = DONE;
      WR:      next_state = DONE;
      RMW_RD:  next_state = RMW_WR;
      RMW_WR:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Memory enables are registered from the next state so they are stable
  // for the whole cycle the memory sees them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      address    <= 32'd0;
      write_data <= 32'd0;
      size_q     <= SZ_B;
      signed_q   <= 1'b0;
      offset_q   <= 2'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state    <= next_state;
      memread  <= (next_state == RD)  || (next_state == RMW_RD);
      memwrite <= (next_state == WR)  || (next_state == RMW_WR);
      if (accept) begin
        size_q   <= req_if.req_size;
        signed_q <= req_if.req_signed;
        offset_q <= eff_addr[1:0];
        wdata_q  <= req_if.req_wdata;
        err_q    <= req_err;
        rdata_q  <= 32'd0;
        if (!req_err) address <= {eff_addr[31:2], 2'b00};
        if (next_state == WR) write_data <= req_if.req_wdata;
      end
      if (state == RD)     rdata_q    <= load_data;
      if (state == RMW_RD) write_data <= merged_word;
    end
  end

  assign req_if.req_ready  = (state == IDLE);
  assign req_if.resp_valid = (state == DONE);
  assign req_if.resp_rdata = (state == DONE) ? rdata_q : 32'd0;
  assign req_if.resp_err   = (state == DONE) && err_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases followed by random traffic, checked
// against a byte-array memory model. Build with ALIGN_CHECK_EN to cover that mode.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread, memwrite;
  logic [31:0] address, write_data, read_data;
  mem_state_e  state_dbg;

  mem_access_if bus ();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_if     (bus.slave),
    .memread    (memread),
    .memwrite   (memwrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign read_data = mem[address[9:2]];
  always @(posedge clk) if (memwrite) mem[address[9:2]] <= write_data;

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_bytes [0:MEM_BYTES-1];
  logic [32:0] exp_q[$];   // {err, rdata}
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_access(input bit wr, input logic [1:0] sz, input bit sgn,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output int lat, output logic [31:0] waddr,
                              output logic [31:0] wword, output int rd_n, output int wr_n);
    int nb;
    bit err;
    longint unsigned ea;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ea  = longint'(addr);
    err = (sz == 2'd3);
`ifdef ALIGN_CHECK_EN
    if ((addr % nb) != 0) err = 1'b1;
`else
    ea = ea - (ea % nb);
`endif
    if (ea + nb > MEM_BYTES) err = 1'b1;
    v = 32'd0; waddr = 32'(ea) & ~32'h3; wword = 32'd0;
    if (err) begin
      lat = 1; rd_n = 0; wr_n = 0;
    end else if (!wr) begin
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_bytes[ea + i]);
      if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      lat = 2; rd_n = 1; wr_n = 0;
    end else begin
      for (int i = 0; i < nb; i++) ref_bytes[ea + i] = 8'(wd >> (8*(nb-1-i)));
      lat = (nb == 4) ? 2 : 3; rd_n = (nb == 4) ? 0 : 1; wr_n = 1;
    end
    if (!err) for (int i = 0; i < 4; i++) wword = (wword << 8) | 32'(ref_bytes[waddr + i]);
    exp_q.push_back({err, v});
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] obs_rdata);
    int lat, rd_n, wr_n, rd_cnt, wr_cnt, obs_lat;
    bit got;
    logic [31:0] waddr, wword;
    logic [32:0] exp;
    logic obs_err;
    model_access(wr, sz, sgn, addr, wd, lat, waddr, wword, rd_n, wr_n);
    @(negedge clk);
    check("ready_idle", bus.req_ready, 1);
    check("resp_idle", bus.resp_valid, 0);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wd;
    @(negedge clk);
    // Junk request held while busy must be ignored.
    bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_signed = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    got = 0; rd_cnt = 0; wr_cnt = 0; obs_lat = 0; obs_rdata = 0; obs_err = 0;
    for (int n = 1; n <= 8 && !got; n++) begin
      if (n > 1) @(negedge clk);
      check("rw_excl", memread & memwrite, 0);
      if (memread) begin
        rd_cnt++;
        check("rd_addr", address, waddr);
      end
      if (memwrite) begin
        wr_cnt++;
        check("wr_addr", address, waddr);
        check("wr_data", write_data, wword);
      end
      if (bus.resp_valid) begin
        got = 1; obs_lat = n; obs_rdata = bus.resp_rdata; obs_err = bus.resp_err;
      end
    end
    bus.req_valid = 1'b0;
    exp = exp_q.pop_front();
    if (!got) begin
      check("resp_timeout", 0, 1);
    end else begin
      check("latency", obs_lat, lat);
      check("rdata", obs_rdata, exp[31:0]);
      check("err", obs_err, exp[32]);
      check("rd_cycles", rd_cnt, rd_n);
      check("wr_cycles", wr_cnt, wr_n);
    end
  endtask

  task automatic reset_during_rmw();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_B;
    bus.req_signed = 1'b0; bus.req_addr = 32'h13; bus.req_wdata = 32'h77;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rmw_rd_state", state_dbg, RMW_RD);
    check("rmw_rd_memread", memread, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_state", state_dbg, IDLE);
    check("rst_memread", memread, 0);
    check("rst_memwrite", memwrite, 0);
    check("rst_resp", bus.resp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_resp", bus.resp_valid, 0);
      check("post_rst_memwrite", memwrite, 0);
    end
    check("rst_word_kept", mem[4], 32'hDEADBEEF);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r;
    logic [1:0]  sz;
    logic [31:0] a;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SZ_W;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;
    for (int i = 0; i < MEM_BYTES; i++) ref_bytes[i] = 8'(mem[i/4] >> (8*(3 - i%4)));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", bus.req_ready, 1);
    check("reset_resp_valid", bus.resp_valid, 0);
    check("reset_resp_err", bus.resp_err, 0);
    check("reset_resp_rdata", bus.resp_rdata, 0);
    check("reset_memread", memread, 0);
    check("reset_memwrite", memwrite, 0);
    check("reset_address", address, 0);
    check("reset_write_data", write_data, 0);
    check("reset_state", state_dbg, IDLE);

    do_req(0, SZ_W, 0, 32'h10, 0, r);  check("lw_10", r, 32'hDEADBEEF);
    do_req(0, SZ_B, 1, 32'h11, 0, r);  check("lb_11", r, 32'hFFFFFFAD);
    do_req(0, SZ_B, 0, 32'h11, 0, r);  check("lbu_11", r, 32'h000000AD);
    do_req(0, SZ_H, 0, 32'h12, 0, r);  check("lhu_12", r, 32'h0000BEEF);
    do_req(0, SZ_H, 1, 32'h10, 0, r);  check("lh_10", r, 32'hFFFFDEAD);
    do_req(1, SZ_B, 0, 32'h12, 32'h55, r);
    do_req(0, SZ_W, 0, 32'h10, 0, r);  check("lw_after_sb", r, 32'hDEAD55EF);
    do_req(1, SZ_H, 0, 32'h11, 32'h1234, r);
    do_req(0, SZ_W, 0, 32'h10, 0, r);
`ifdef ALIGN_CHECK_EN
    check("sh_misaligned_kept", r, 32'hDEAD55EF);
`else
    check("sh_forced_align", r, 32'h123455EF);
`endif
    do_req(1, SZ_W, 0, 32'h10, 32'hDEADBEEF, r);
    reset_during_rmw();
    do_req(0, SZ_INV, 0, 32'h10, 0, r);
    do_req(1, SZ_INV, 0, 32'h10, 32'h1, r);
    do_req(0, SZ_W, 0, 32'h400, 0, r);
    do_req(1, SZ_W, 0, 32'h3FC, 32'hCAFEF00D, r);
    do_req(0, SZ_B, 0, 32'h3FF, 0, r);
    do_req(1, SZ_H, 0, 32'h3FF, 32'hABCD, r);

    for (int t = 0; t < 400; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? SZ_INV : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(1016, 1100));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, MEM_BYTES - 1));
      endcase
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, r);
    end

    @(negedge clk);
    for (int i = 0; i < 256; i++)
      check("mem_final", mem[i], {ref_bytes[4*i], ref_bytes[4*i+1], ref_bytes[4*i+2], ref_bytes[4*i+3]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
